id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register with operand forwarding and a load-use hazard interlock; sits between decode and the ALU.
//   Captures decoded operands/control, drives ALU a/b/ALUSel, inserts bubbles on load-use hazards, and honours flush/stall.
// PARAMETERS
//   XLEN      32    datapath width (ALU is 32-bit; only 32 supported)
//   NOP_SEL   4'hF  ALUSel driven for bubbles/reset (ALU no-op code)
// PORTS
//   clk           in   1     rising-edge clock
//   rst_n         in   1     asynchronous, active-low reset
//   dec_valid     in   1     decode presents an instruction
//   dec_ready     out  1     stage accepts decode this cycle
//   dec_pc        in   32    instruction PC
//   dec_rs1/rs2   in   5     source register indices
//   dec_use_rs1/2 in   1     instruction reads rs1/rs2
//   dec_rs1_data  in   32    register-file rs1 value
//   dec_rs2_data  in   32    register-file rs2 value
//   dec_imm       in   32    sign-extended immediate
//   dec_rd        in   5     destination index
//   dec_alu_sel   in   4     ALU function code
//   dec_a_pc      in   1     ALU a = PC instead of rs1
//   dec_b_imm     in   1     ALU b = imm instead of rs2
//   dec_mem_rd/wr in   1     load / store
//   dec_reg_wr    in   1     writes rd
//   ex_stall      in   1     downstream hold (e.g. memory wait)
//   flush         in   1     kill the instruction held in this stage (branch redirect)
//   exm_rd/exm_reg_wr/exm_result   in 5/1/32   EX/MEM forward source
//   mwb_rd/mwb_reg_wr/mwb_result   in 5/1/32   MEM/WB forward source
//   ex_valid      out  1     stage holds a live instruction
//   alu_a, alu_b  out  32    ALU operands (combinational from the register + forwarding)
//   alu_sel       out  4     ALU function; NOP_SEL when !ex_valid
//   ex_rs2_fwd    out  32    forwarded rs2 (store data)
//   ex_rd, ex_pc, ex_imm, ex_mem_rd, ex_mem_wr, ex_reg_wr   out   registered control, all 0 when !ex_valid
// BEHAVIOUR
//   Reset: every register 0, ex_valid=0, alu_sel=NOP_SEL, dec_ready=0 while rst_n low.
//   Hazard hz = dec_valid & ex_valid & ex_mem_rd & ex_rd!=0 &
//     ((dec_use_rs1 & dec_rs1==ex_rd) | (dec_use_rs2 & dec_rs2==ex_rd)).
//   Per-edge priority: flush -> ex_valid<=0, control cleared (overrides all);
//     else ex_stall -> hold all registers; else hz -> load bubble (ex_valid<=0, ALU sel NOP);
//     else load decode fields, ex_valid<=dec_valid.
//   dec_ready = rst_n & !ex_stall & !hz (flush does not drop dec_ready; the decode item is lost, and decode flushes itself).
//   FSM: RUN (normal) / BUBBLE (one cycle after hz). BUBBLE->RUN unconditionally; the load has advanced, so
//     MEM/WB forwarding covers it. Exactly one bubble per load-use.
//   Forwarding per source: src!=0 & exm_reg_wr & exm_rd==src -> exm_result;
//     else mwb_reg_wr & mwb_rd==src -> mwb_result; else the registered regfile data. x0 is never forwarded (reads 0).
//   alu_a = ex_a_pc ? ex_pc : fwd(rs1); alu_b = ex_b_imm ? ex_imm : fwd(rs2). Zero-latency combinational path.
//   Register file is write-before-read: no hazard against the writeback stage.
//   Reset mid-operation: the live instruction is discarded; no partial state survives.
// CONFIGURATION
//   ID_EX_FWD_EN defined: forwarding as above.
//   Undefined: no forwarding (operands = registered regfile data). hz is widened to any RAW against this stage
//     (ex_reg_wr) or EX/MEM (exm_reg_wr), rd!=0. A bubble is inserted each cycle until clear (up to 2).
// STRUCTURE
//   Shared package riscv_pkg: ALU op codes (ALUadd..ALUnop), NOP_SEL, XLEN, fwd_sel_t {FWD_RF, FWD_EXM, FWD_MWB}.
//   One sub-module, fwd_mux (select + 3:1 mux), instantiated for rs1 and rs2.
// TESTING
//   1 Reset: rst_n=0 mid-stream -> ex_valid=0, alu_sel=4'hF, all outputs 0 on the same cycle.
//   2 add x3,x1,x2 then sub x4,x3,x1 (exm_rd=3, exm_result=0x10, rs1 data stale 0x0) -> alu_a=0x10 with no stall.
//   3 lw x5 in EX, next add x6,x5,x5 -> dec_ready=0 for 1 cycle, one bubble (alu_sel=F), then alu_a=alu_b=mwb_result.
//   4 Both exm_rd and mwb_rd = 7 (0xA / 0xB) -> forwarded value 0xA (EX/MEM wins); rd=0 with result 0xFF -> operand 0.
//   5 flush asserted together with ex_stall and hz -> next cycle ex_valid=0, control zero.
//   6 ex_stall held 3 cycles -> outputs constant, dec_ready=0; release -> next instruction loads.
//   Rerun 2-4 with ID_EX_FWD_EN undefined -> case 2 stalls 2 cycles with alu_a = refreshed regfile data.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, ALU codes, the ID/EX
// register layout, forwarding selects and small hazard helpers.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALUadd  = 4'h0,
    ALUsub  = 4'h1,
    ALUand  = 4'h2,
    ALUor   = 4'h3,
    ALUxor  = 4'h4,
    ALUsll  = 4'h5,
    ALUsrl  = 4'h6,
    ALUsra  = 4'h7,
    ALUslt  = 4'h8,
    ALUsltu = 4'h9,
    ALUlui  = 4'hA,
    ALUnop  = 4'hF
  } alu_op_e;

  localparam logic [3:0] NOP_SEL = ALUnop;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EXM,
    FWD_MWB
  } fwd_sel_t;

  typedef enum logic [0:0] {
    StRun,
    StBubble
  } id_ex_state_e;

  // Everything the ID/EX register captures from decode.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [3:0]      alu_sel;
    logic            a_pc;
    logic            b_imm;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
  } id_ex_t;

  // A writer hits a source only for a real (non-x0) register.
  function automatic logic src_match(input logic [4:0] src, input logic [4:0] rd,
                                     input logic wr);
    return wr && (src != 5'd0) && (src == rd);
  endfunction

  // Does the decoding instruction read register rd (x0 never counts)?
  function automatic logic raw_hit(input logic use1, input logic [4:0] rs1,
                                   input logic use2, input logic [4:0] rs2,
                                   input logic [4:0] rd);
    return (rd != 5'd0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding: picks EX/MEM, MEM/WB or the registered regfile value for
// one source register. With FwdEn=0 the regfile value is always used.
module fwd_mux import riscv_pkg::*; #(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter bit          FwdEn = 1'b1
) (
  input  logic [4:0]      src,
  input  logic [XLEN-1:0] rf_data,
  input  logic [4:0]      exm_rd,
  input  logic            exm_reg_wr,
  input  logic [XLEN-1:0] exm_result,
  input  logic [4:0]      mwb_rd,
  input  logic            mwb_reg_wr,
  input  logic [XLEN-1:0] mwb_result,
  output logic [XLEN-1:0] data
);

  fwd_sel_t sel;

  // Select the youngest matching producer; EX/MEM beats MEM/WB.
  always_comb begin
    sel = FWD_RF;
    if (FwdEn) begin
      if (src_match(src, exm_rd, exm_reg_wr)) begin
        sel = FWD_EXM;
      end else if (src_match(src, mwb_rd, mwb_reg_wr)) begin
        sel = FWD_MWB;
      end
    end
  end

  // 3:1 operand mux; x0 always reads zero.
  always_comb begin
    data = rf_data;
    case (sel)
      FWD_EXM: data = exm_result;
      FWD_MWB: data = mwb_result;
      default: data = rf_data;
    endcase
    if (src == 5'd0) begin
      data = '0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use interlock.
// Build option ID_EX_FWD_EN: defined enables EX/MEM and MEM/WB forwarding;
// undefined stalls decode on any RAW against this stage or EX/MEM instead.
module id_ex_stage import riscv_pkg::*; #(
  parameter int unsigned XLEN    = riscv_pkg::XLEN,
  parameter logic [3:0]  NOP_SEL = riscv_pkg::NOP_SEL
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [XLEN-1:0] dec_pc,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic            dec_use_rs1,
  input  logic            dec_use_rs2,
  input  logic [XLEN-1:0] dec_rs1_data,
  input  logic [XLEN-1:0] dec_rs2_data,
  input  logic [XLEN-1:0] dec_imm,
  input  logic [4:0]      dec_rd,
  input  logic [3:0]      dec_alu_sel,
  input  logic            dec_a_pc,
  input  logic            dec_b_imm,
  input  logic            dec_mem_rd,
  input  logic            dec_mem_wr,
  input  logic            dec_reg_wr,
  input  logic            ex_stall,
  input  logic            flush,
  input  logic [4:0]      exm_rd,
  input  logic            exm_reg_wr,
  input  logic [XLEN-1:0] exm_result,
  input  logic [4:0]      mwb_rd,
  input  logic            mwb_reg_wr,
  input  logic [XLEN-1:0] mwb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_sel,
  output logic [XLEN-1:0] ex_rs2_fwd,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_reg_wr
);

`ifdef ID_EX_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  id_ex_t       ex_q, ex_d;
  id_ex_state_e state_q, state_d;
  logic         hz;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  // Hazard detection against the instruction held here (and EX/MEM without forwarding).
  always_comb begin
`ifdef ID_EX_FWD_EN
    // Only a load in EX cannot be forwarded; one bubble lets it reach MEM/WB.
    hz = dec_valid && ex_q.valid && ex_q.mem_rd && (state_q == StRun) &&
         raw_hit(dec_use_rs1, dec_rs1, dec_use_rs2, dec_rs2, ex_q.rd);
`else
    // Without forwarding wait until the producer has reached writeback.
    hz = dec_valid &&
         ((ex_q.valid && ex_q.reg_wr &&
           raw_hit(dec_use_rs1, dec_rs1, dec_use_rs2, dec_rs2, ex_q.rd)) ||
          (exm_reg_wr && raw_hit(dec_use_rs1, dec_rs1, dec_use_rs2, dec_rs2, exm_rd)));
`endif
  end

  // Next-state: flush > stall > bubble > load from decode.
  always_comb begin
    ex_d    = ex_q;
    state_d = StRun;
    if (flush) begin
      ex_d = '0;
    end else if (ex_stall) begin
      ex_d = ex_q;
    end else if (hz) begin
      ex_d    = '0;
      state_d = StBubble;
    end else begin
      ex_d.valid    = dec_valid;
      ex_d.pc       = dec_pc;
      ex_d.rs1      = dec_rs1;
      ex_d.rs2      = dec_rs2;
      ex_d.rs1_data = dec_rs1_data;
      ex_d.rs2_data = dec_rs2_data;
      ex_d.imm      = dec_imm;
      ex_d.rd       = dec_rd;
      ex_d.alu_sel  = dec_alu_sel;
      ex_d.a_pc     = dec_a_pc;
      ex_d.b_imm    = dec_b_imm;
      ex_d.mem_rd   = dec_mem_rd;
      ex_d.mem_wr   = dec_mem_wr;
      ex_d.reg_wr   = dec_reg_wr;
    end
  end

  // Pipeline register and bubble-tracking state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      state_q <= StRun;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
    end
  end

  fwd_mux #(
    .XLEN (XLEN),
    .FwdEn(FwdEn)
  ) u_fwd_rs1 (
    .src       (ex_q.rs1),
    .rf_data   (ex_q.rs1_data),
    .exm_rd    (exm_rd),
    .exm_reg_wr(exm_reg_wr),
    .exm_result(exm_result),
    .mwb_rd    (mwb_rd),
    .mwb_reg_wr(mwb_reg_wr),
    .mwb_result(mwb_result),
    .data      (rs1_fwd)
  );

  fwd_mux #(
    .XLEN (XLEN),
    .FwdEn(FwdEn)
  ) u_fwd_rs2 (
    .src       (ex_q.rs2),
    .rf_data   (ex_q.rs2_data),
    .exm_rd    (exm_rd),
    .exm_reg_wr(exm_reg_wr),
    .exm_result(exm_result),
    .mwb_rd    (mwb_rd),
    .mwb_reg_wr(mwb_reg_wr),
    .mwb_result(mwb_result),
    .data      (rs2_fwd)
  );

  // Outputs: operand muxing, and control zeroed whenever the stage is empty.
  always_comb begin
    dec_ready  = rst_n && !ex_stall && !hz;
    ex_valid   = ex_q.valid;
    alu_a      = ex_q.a_pc ? ex_q.pc : rs1_fwd;
    alu_b      = ex_q.b_imm ? ex_q.imm : rs2_fwd;
    ex_rs2_fwd = rs2_fwd;
    alu_sel    = NOP_SEL;
    ex_rd      = '0;
    ex_pc      = '0;
    ex_imm     = '0;
    ex_mem_rd  = 1'b0;
    ex_mem_wr  = 1'b0;
    ex_reg_wr  = 1'b0;
    if (ex_q.valid && (state_q == StRun)) begin
      alu_sel   = ex_q.alu_sel;
      ex_rd     = ex_q.rd;
      ex_pc     = ex_q.pc;
      ex_imm    = ex_q.imm;
      ex_mem_rd = ex_q.mem_rd;
      ex_mem_wr = ex_q.mem_wr;
      ex_reg_wr = ex_q.reg_wr;
    end
  end

endmodule
